// File: rtl/credit_link_tx.sv
// Credit-based link transmitter: pops the upstream fifo while downstream credits remain and registers flits onto the link.
// Optional CREDIT_LINK_TX_STATS_EN adds flit_cnt_o / stall_cnt_o statistics counters.
module credit_link_tx #(
   parameter int SIZE    = 8,
   parameter int CREDITS = 16,
   parameter int CW      = 5
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            enable_i,
   input  logic            fifo_empty_i,
   input  logic [SIZE-1:0] fifo_item_i,
   output logic            fifo_read_o,
   output logic            link_valid_o,
   output logic [SIZE-1:0] link_data_o,
   input  logic            credit_in_i,
   output logic [CW-1:0]   credits_o,
   output logic [1:0]      state_o,
   output logic            err_ovf_o
`ifdef CREDIT_LINK_TX_STATS_EN
   ,
   output logic [15:0]     flit_cnt_o,
   output logic [15:0]     stall_cnt_o
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      STALL = 2'd2
   } state_e;

   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
   localparam logic [CW-1:0] CRED_ONE = CW'(1);

   state_e            state_q, state_d;
   logic [CW-1:0]     credits_q, credits_d;
   logic              link_valid_q, link_valid_d;
   logic [SIZE-1:0]   link_data_q, link_data_d;
   logic              err_q, err_d;
   logic              send;
   logic              blocked;

   // Reset is folded in so no pop escapes while the block is held in reset.
   assign send    = rst_ni & enable_i & ~fifo_empty_i & (credits_q != '0);
   assign blocked = enable_i & ~fifo_empty_i & (credits_q == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         credits_q    <= CRED_MAX;
         link_valid_q <= 1'b0;
         link_data_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         credits_q    <= credits_d;
         link_valid_q <= link_valid_d;
         link_data_q  <= link_data_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = IDLE;
      credits_d    = credits_q;
      err_d        = err_q;
      link_valid_d = send;
      link_data_d  = link_data_q;

      if (send) begin
         link_data_d = fifo_item_i;
      end

      // A credit arriving alongside a pop cancels it out.
      case ({send, credit_in_i})
         2'b10: credits_d = credits_q - CRED_ONE;
         2'b01: begin
            if (credits_q == CRED_MAX) begin
               err_d = 1'b1;
            end else begin
               credits_d = credits_q + CRED_ONE;
            end
         end
         default: ;
      endcase

      if (send) begin
         state_d = SEND;
      end else if (blocked) begin
         state_d = STALL;
      end
   end

   assign fifo_read_o  = send;
   assign link_valid_o = link_valid_q;
   assign link_data_o  = link_data_q;
   assign credits_o    = credits_q;
   assign state_o      = state_q;
   assign err_ovf_o    = err_q;

`ifdef CREDIT_LINK_TX_STATS_EN
   logic [15:0] flit_cnt_q, flit_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flit_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         flit_cnt_q  <= flit_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Flit count wraps; stall count sticks at its maximum.
   always_comb begin
      flit_cnt_d  = flit_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (send) begin
         flit_cnt_d = flit_cnt_q + 16'd1;
      end
      if ((state_q == STALL) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   assign flit_cnt_o  = flit_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_credit_link_tx.sv
// Bench for credit_link_tx: queue-based fifo and credit model checked every cycle, plus directed literal checks.
module tb_credit_link_tx;
   localparam int SIZE    = 8;
   localparam int CREDITS = 16;
   localparam int CW      = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            enable = 1'b0;
   logic            fifo_empty = 1'b1;
   logic [SIZE-1:0] fifo_item = '0;
   logic            credit_in = 1'b0;
   logic            fifo_read;
   logic            link_valid;
   logic [SIZE-1:0] link_data;
   logic [CW-1:0]   credits;
   logic [1:0]      state;
   logic            err_ovf;
`ifdef CREDIT_LINK_TX_STATS_EN
   logic [15:0]     flit_cnt;
   logic [15:0]     stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   logic [SIZE-1:0] fq[$];

   // Reference model state
   int              m_cred  = CREDITS;
   bit              m_valid = 1'b0;
   logic [SIZE-1:0] m_data  = '0;
   int              m_state = 0;
   bit              m_err   = 1'b0;
   int              m_flit  = 0;
   int              m_stall = 0;
   bit              mp;
   int              mold;

   credit_link_tx #(.SIZE(SIZE), .CREDITS(CREDITS), .CW(CW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .enable_i     (enable),
      .fifo_empty_i (fifo_empty),
      .fifo_item_i  (fifo_item),
      .fifo_read_o  (fifo_read),
      .link_valid_o (link_valid),
      .link_data_o  (link_data),
      .credit_in_i  (credit_in),
      .credits_o    (credits),
      .state_o      (state),
      .err_ovf_o    (err_ovf)
`ifdef CREDIT_LINK_TX_STATS_EN
      ,
      .flit_cnt_o   (flit_cnt),
      .stall_cnt_o  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic refresh();
      fifo_empty = (fq.size() == 0);
      fifo_item  = fifo_empty ? SIZE'($urandom) : fq[0];
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      refresh();
   endtask

   task automatic push(input logic [SIZE-1:0] v);
      fq.push_back(v);
      refresh();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      enable    = 1'b0;
      credit_in = 1'b0;
      fq.delete();
      refresh();
      tick();
      rst_n = 1'b1;
   endtask

   // Behavioural model: pop when allowed, count credits, remember the last flit.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cred  = CREDITS;
         m_valid = 1'b0;
         m_data  = '0;
         m_state = 0;
         m_err   = 1'b0;
         m_flit  = 0;
         m_stall = 0;
      end else begin
         mp   = enable && !fifo_empty && (m_cred != 0);
         mold = m_state;
         m_state = mp ? 1 : ((enable && !fifo_empty && m_cred == 0) ? 2 : 0);
         if (mold == 2 && m_stall != 65535) m_stall++;
         if (mp) begin
            m_flit = (m_flit + 1) % 65536;
            m_data = fq.pop_front();
         end
         m_valid = mp;
         if (mp && !credit_in) m_cred--;
         else if (!mp && credit_in) begin
            if (m_cred == CREDITS) m_err = 1'b1;
            else m_cred++;
         end
      end
   end

   always @(negedge clk) begin
      chk("fifo_read", fifo_read, rst_n && enable && !fifo_empty && (m_cred != 0));
      chk("link_valid", link_valid, m_valid);
      chk("link_data", link_data, m_data);
      chk("credits", credits, m_cred);
      chk("state", state, m_state);
      chk("err_ovf", err_ovf, m_err);
`ifdef CREDIT_LINK_TX_STATS_EN
      chk("flit_cnt", flit_cnt, m_flit);
      chk("stall_cnt", stall_cnt, m_stall);
`endif
   end

   initial begin
      int pops;
      logic [SIZE-1:0] items [3];
      items[0] = 8'hA1;
      items[1] = 8'hB2;
      items[2] = 8'hC3;
      refresh();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // 1: three flits A,B,C
      do_reset();
      for (int i = 0; i < 3; i++) push(items[i]);
      enable = 1'b1;
      #1 chk("t1_pop0", fifo_read, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("t1_valid", link_valid, 1);
         chk("t1_data", link_data, items[i]);
      end
      chk("t1_credits", credits, 13);
      chk("t1_nopop", fifo_read, 0);
      tick();
      #1 chk("t1_idle_valid", link_valid, 0);

      // 2: credit exhaustion
      do_reset();
      for (int i = 0; i < 20; i++) push(SIZE'(i + 1));
      enable = 1'b1;
      pops = 0;
      repeat (20) begin
         #1 if (fifo_read) pops++;
         tick();
      end
      #1;
      chk("t2_pops", pops, 16);
      chk("t2_credits", credits, 0);
      chk("t2_state", state, 2);
      chk("t2_nopop", fifo_read, 0);

      // 3: single credit return
      credit_in = 1'b1;
      #1 chk("t3_nopop", fifo_read, 0);
      tick();
      credit_in = 1'b0;
      #1;
      chk("t3_credits1", credits, 1);
      chk("t3_pop", fifo_read, 1);
      tick();
      #1;
      chk("t3_credits0", credits, 0);
      chk("t3_nopop2", fifo_read, 0);
      chk("t3_valid", link_valid, 1);

      // 4: pop and credit in the same cycle
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 11; i++) push(SIZE'(i + 8'h40));
      repeat (11) tick();
      #1 chk("t4_credits5", credits, 5);
      push(8'h5A);
      credit_in = 1'b1;
      #1 chk("t4_pop", fifo_read, 1);
      tick();
      credit_in = 1'b0;
      #1;
      chk("t4_credits", credits, 5);
      chk("t4_valid", link_valid, 1);
      chk("t4_data", link_data, 8'h5A);

      // 5: overflow credit while full
      do_reset();
      credit_in = 1'b1;
      tick();
      credit_in = 1'b0;
      #1;
      chk("t5_credits", credits, 16);
      chk("t5_err", err_ovf, 1);
      repeat (5) tick();
      #1 chk("t5_err_sticky", err_ovf, 1);
      do_reset();
      #1 chk("t5_err_clr", err_ovf, 0);

      // 6: asynchronous reset mid-burst
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 10; i++) push(SIZE'(i + 8'h70));
      repeat (3) tick();
      #1 chk("t6_pre_valid", link_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_valid", link_valid, 0);
      chk("t6_credits", credits, 16);
      chk("t6_state", state, 0);
      chk("t6_nopop", fifo_read, 0);
`ifdef CREDIT_LINK_TX_STATS_EN
      chk("t6_flit", flit_cnt, 0);
      chk("t6_stall", stall_cnt, 0);
`endif
      do_reset();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         enable = ($urandom_range(9) != 0);
         if (fq.size() < 6 && $urandom_range(1) == 1) push(SIZE'($urandom));
         credit_in = (m_cred < CREDITS) ? ($urandom_range(2) == 0) : ($urandom_range(39) == 0);
         if ($urandom_range(699) == 0) begin
            do_reset();
         end else begin
            tick();
         end
      end

      enable    = 1'b0;
      credit_in = 1'b0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
